// File: rtl/dw_fp_mfunc_sched.sv
// Round-robin scheduler sharing one multicycle FP multifunction unit among NUM_REQ requesters.
// Optional macro DW_FP_MFUNC_SCHED_FUNC_CHK_EN rejects non-one-hot or unsupported func selects.
module dw_fp_mfunc_sched #(
   parameter int sig_width   = 23,
   parameter int exp_width   = 8,
   parameter int NUM_REQ     = 4,
   parameter int MC_CYCLES   = 3,
   parameter int func_select = 127
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [NUM_REQ-1:0]                      req,
   input  logic [NUM_REQ*(sig_width+exp_width+1)-1:0] req_a,
   input  logic [NUM_REQ*16-1:0]                   req_func,
   input  logic [NUM_REQ*3-1:0]                    req_rnd,
   output logic [NUM_REQ-1:0]                      gnt,
   output logic                                    rsp_valid,
   input  logic                                    rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]              rsp_id,
   output logic [sig_width+exp_width:0]            rsp_z,
   output logic [7:0]                              rsp_status,
   output logic [sig_width+exp_width:0]            fu_a,
   output logic [15:0]                             fu_func,
   output logic [2:0]                              fu_rnd,
   output logic                                    fu_dg_ctrl,
   input  logic [sig_width+exp_width:0]            fu_z,
   input  logic [7:0]                              fu_status
);

   localparam int W  = sig_width + exp_width + 1;
   localparam int IW = $clog2(NUM_REQ);
   localparam logic [IW:0] NREQ_W = (IW+1)'(NUM_REQ);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [3:0]    r_cnt;
   logic [IW-1:0] r_ptr;
   logic          r_bad;

   logic [NUM_REQ-1:0] w_rot;
   logic [IW-1:0]      w_off;
   logic [IW:0]        w_sum;
   logic [IW-1:0]      w_win;
   logic [IW-1:0]      w_ptr_nxt;
   logic [15:0]        w_func;
   logic               w_func_bad;
   logic               w_accept;
   logic               w_finish;
   logic               w_release;

   // Rotate requests so the slot after the previous winner sits at bit 0, then take the lowest set bit.
   assign w_rot = NUM_REQ'({req, req} >> r_ptr);

   always_comb begin
      w_off = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         if (w_rot[k]) w_off = IW'(k);
      end
   end

   assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_win     = (w_sum >= NREQ_W) ? IW'(w_sum - NREQ_W) : IW'(w_sum);
   assign w_ptr_nxt = (w_win == IW'(NUM_REQ-1)) ? '0 : w_win + IW'(1);
   assign w_func    = req_func[w_win*16 +: 16];

`ifdef DW_FP_MFUNC_SCHED_FUNC_CHK_EN
   localparam logic [15:0] FSEL = 16'(func_select);
   assign w_func_bad = (w_func == 16'h0) || ((w_func & (w_func - 16'd1)) != 16'h0)
                       || ((w_func & ~FSEL) != 16'h0);
`else
   assign w_func_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (|req) w_next = BUSY;
         BUSY:    if (r_bad || (r_cnt == 4'd0)) w_next = RESP;
         RESP:    if (rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_accept  = 1'b0;
      w_finish  = 1'b0;
      w_release = 1'b0;
      case (r_state)
         IDLE:    w_accept  = |req;
         BUSY:    w_finish  = r_bad || (r_cnt == 4'd0);
         RESP:    w_release = rsp_ready;
         default: ;
      endcase
   end

   // fu_* only load on acceptance so the unit inputs stay quiet outside an operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt        <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_z      <= '0;
         rsp_status <= '0;
         fu_a       <= '0;
         fu_func    <= '0;
         fu_rnd     <= '0;
         fu_dg_ctrl <= 1'b0;
         r_cnt      <= '0;
         r_ptr      <= '0;
         r_bad      <= 1'b0;
      end else begin
         gnt <= '0;
         if (w_accept) begin
            gnt        <= NUM_REQ'(1) << w_win;
            rsp_id     <= w_win;
            fu_a       <= req_a[w_win*W +: W];
            fu_func    <= w_func;
            fu_rnd     <= req_rnd[w_win*3 +: 3];
            fu_dg_ctrl <= !w_func_bad;
            r_bad      <= w_func_bad;
            r_cnt      <= 4'(MC_CYCLES-1);
            r_ptr      <= w_ptr_nxt;
         end
         if (w_finish) begin
            rsp_valid  <= 1'b1;
            fu_dg_ctrl <= 1'b0;
            r_bad      <= 1'b0;
            if (r_bad) begin
               rsp_z      <= '0;
               rsp_status <= 8'h04;
            end else begin
               rsp_z      <= fu_z;
               rsp_status <= fu_status;
            end
         end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_release) rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dw_fp_mfunc_sched.sv
// Self-checking bench for dw_fp_mfunc_sched: scoreboard of expected responses plus a cycle-exact
// round-robin model; scenario expectations adapt when DW_FP_MFUNC_SCHED_FUNC_CHK_EN is defined.
module tb_dw_fp_mfunc_sched;

   localparam int SW = 23;
   localparam int EW = 8;
   localparam int W  = SW + EW + 1;
   localparam int NR = 4;
   localparam int MC = 3;
   localparam logic [31:0] KZ = 32'h5A5A_0F0F;
`ifdef DW_FP_MFUNC_SCHED_FUNC_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct {
      logic [1:0]  id;
      logic [31:0] z;
      logic [7:0]  st;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic [NR-1:0] req;
   logic [NR*W-1:0]  reqAPacked;
   logic [NR*16-1:0] reqFuncPacked;
   logic [NR*3-1:0]  reqRndPacked;
   logic [NR-1:0] gnt;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_id;
   logic [W-1:0]  rsp_z;
   logic [7:0]    rsp_status;
   logic [W-1:0]  fu_a;
   logic [15:0]   fu_func;
   logic [2:0]    fu_rnd;
   logic          fu_dg_ctrl;
   logic [W-1:0]  fu_z;
   logic [7:0]    fu_status;

   logic [31:0] reqA    [NR];
   logic [15:0] reqFunc [NR];
   logic [2:0]  reqRnd  [NR];

   exp_t       sbq[$];
   logic [1:0] mPtr;
   int         nChecks;
   int         nFail;

   dw_fp_mfunc_sched #(
      .sig_width(SW), .exp_width(EW), .NUM_REQ(NR), .MC_CYCLES(MC), .func_select(127)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_a(reqAPacked), .req_func(reqFuncPacked),
      .req_rnd(reqRndPacked), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_status(rsp_status), .fu_a(fu_a), .fu_func(fu_func),
      .fu_rnd(fu_rnd), .fu_dg_ctrl(fu_dg_ctrl), .fu_z(fu_z), .fu_status(fu_status)
   );

   // Stand-in for the shared unit: a recognisable function of its current inputs.
   assign fu_z      = fu_a ^ KZ;
   assign fu_status = {fu_rnd, fu_func[4:0]};

   always_comb begin
      for (int k = 0; k < NR; k++) begin
         reqAPacked[k*W +: W]     = reqA[k];
         reqFuncPacked[k*16 +: 16] = reqFunc[k];
         reqRndPacked[k*3 +: 3]   = reqRnd[k];
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: sim time exceeded, required finish before 500000");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [1:0] rrPick(input logic [1:0] p, input logic [3:0] r);
      rrPick = p;
      for (int k = 3; k >= 0; k--)
         if (r[(int'(p) + k) % 4]) rrPick = 2'((int'(p) + k) % 4);
   endfunction

   // Model step at an accepting edge: pick winner from current req, advance pointer, queue result.
   task automatic expect_grant(output logic [1:0] win);
      exp_t e;
      win  = rrPick(mPtr, req);
      mPtr = win + 2'd1;
      e.id = win;
      e.z  = reqA[win] ^ KZ;
      e.st = {reqRnd[win], reqFunc[win][4:0]};
      if (CHK && (($countones(reqFunc[win]) != 1) || ((reqFunc[win] & ~16'h007F) != 16'h0))) begin
         e.z  = '0;
         e.st = 8'h04;
      end
      sbq.push_back(e);
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      rst_n = 1'b0;
      req = '0;
      rsp_ready = 1'b1;
      for (int k = 0; k < NR; k++) begin
         reqA[k] = 32'h0; reqFunc[k] = 16'h0; reqRnd[k] = 3'h0;
      end
      repeat (2) @(negedge clk);
      nChecks++;
      if ({gnt, rsp_valid, rsp_id} !== '0) begin
         nFail++;
         $display("[TB] FAIL reset_ctrl: got gnt=%b valid=%b id=%0d, required all 0", gnt, rsp_valid, rsp_id);
      end
      nChecks++;
      if ({rsp_z, rsp_status} !== '0) begin
         nFail++;
         $display("[TB] FAIL reset_rsp: got z=%h st=%h, required 0", rsp_z, rsp_status);
      end
      nChecks++;
      if ({fu_a, fu_func, fu_rnd, fu_dg_ctrl} !== '0) begin
         nFail++;
         $display("[TB] FAIL reset_fu: got a=%h f=%h r=%h dg=%b, required 0", fu_a, fu_func, fu_rnd, fu_dg_ctrl);
      end
      rst_n = 1'b1;
      mPtr = 2'd0;
      @(negedge clk);
      nChecks++;
      if ({gnt, rsp_valid, fu_dg_ctrl} !== '0) begin
         nFail++;
         $display("[TB] FAIL reset_idle: got gnt=%b valid=%b dg=%b, required 0", gnt, rsp_valid, fu_dg_ctrl);
      end
   endtask

   task automatic test_single();
      logic [1:0] win;
      exp_t e;
      $display("[TB] test_single");
      reqA[1] = 32'h3F80_1234; reqFunc[1] = 16'h0001; reqRnd[1] = 3'b010;
      rsp_ready = 1'b1;
      req = 4'b0010;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (n == 0) begin
            expect_grant(win);
            req = 4'b0000;
         end
         nChecks++;
         if (gnt !== ((n == 0) ? 4'b0010 : 4'b0000)) begin
            nFail++;
            $display("[TB] FAIL single_gnt n=%0d: got %b", n, gnt);
         end
         nChecks++;
         if (fu_dg_ctrl !== (n < MC)) begin
            nFail++;
            $display("[TB] FAIL single_dg n=%0d: got %b, required %b", n, fu_dg_ctrl, (n < MC));
         end
         nChecks++;
         if (fu_a !== 32'h3F80_1234) begin
            nFail++;
            $display("[TB] FAIL single_fu_a n=%0d: got %h, required 3f801234", n, fu_a);
         end
         nChecks++;
         if (rsp_valid !== (n == MC)) begin
            nFail++;
            $display("[TB] FAIL single_valid n=%0d: got %b, required %b", n, rsp_valid, (n == MC));
         end
         if (rsp_valid && sbq.size() > 0) begin
            e = sbq.pop_front();
            nChecks++;
            if ({rsp_id, rsp_z, rsp_status} !== {e.id, e.z, e.st}) begin
               nFail++;
               $display("[TB] FAIL single_rsp: got id=%0d z=%h st=%h, required id=%0d z=%h st=%h",
                        rsp_id, rsp_z, rsp_status, e.id, e.z, e.st);
            end
         end
      end
   endtask

   task automatic test_contention();
      logic [1:0] win;
      exp_t e;
      $display("[TB] test_contention");
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mPtr = 2'd0;
      for (int k = 0; k < NR; k++) begin
         reqA[k] = 32'h1000_0000 * (k + 1) + 32'h55; reqFunc[k] = 16'h0001 << k; reqRnd[k] = 3'(k);
      end
      rsp_ready = 1'b1;
      req = 4'b1111;
      for (int n = 0; n < 5 * (MC + 2); n++) begin
         @(negedge clk);
         if ((n % (MC + 2)) == 0) begin
            expect_grant(win);
            nChecks++;
            if (gnt !== (4'b0001 << win)) begin
               nFail++;
               $display("[TB] FAIL contention_gnt n=%0d: got %b, required %b", n, gnt, 4'b0001 << win);
            end
         end else begin
            nChecks++;
            if (gnt !== 4'b0000) begin
               nFail++;
               $display("[TB] FAIL contention_gnt n=%0d: got %b, required 0000", n, gnt);
            end
         end
         nChecks++;
         if (rsp_valid !== ((n % (MC + 2)) == MC)) begin
            nFail++;
            $display("[TB] FAIL contention_valid n=%0d: got %b", n, rsp_valid);
         end
         if (rsp_valid && sbq.size() > 0) begin
            e = sbq.pop_front();
            nChecks++;
            if ({rsp_id, rsp_z, rsp_status} !== {e.id, e.z, e.st}) begin
               nFail++;
               $display("[TB] FAIL contention_rsp: got id=%0d z=%h st=%h, required id=%0d z=%h st=%h",
                        rsp_id, rsp_z, rsp_status, e.id, e.z, e.st);
            end
         end
      end
      req = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [1:0] win;
      exp_t e;
      exp_t held;
      $display("[TB] test_backpressure");
      reqA[0] = 32'hC0DE_0001; reqFunc[0] = 16'h0002; reqRnd[0] = 3'b001;
      reqA[2] = 32'h4049_0FDB; reqFunc[2] = 16'h0010; reqRnd[2] = 3'b100;
      rsp_ready = 1'b0;
      req = 4'b0001;
      held = '{id: 2'd0, z: 32'h0, st: 8'h0};
      for (int n = 0; n < MC + 16; n++) begin
         @(negedge clk);
         if (n == 0) begin
            expect_grant(win);
            req = 4'b0100;
         end
         if (n == MC + 11) begin
            expect_grant(win);
            req = 4'b0000;
         end
         nChecks++;
         if (gnt !== ((n == 0) ? 4'b0001 : (n == MC + 11) ? 4'b0100 : 4'b0000)) begin
            nFail++;
            $display("[TB] FAIL backpressure_gnt n=%0d: got %b", n, gnt);
         end
         nChecks++;
         if (rsp_valid !== ((n >= MC && n <= MC + 9) || n == 2 * MC + 11)) begin
            nFail++;
            $display("[TB] FAIL backpressure_valid n=%0d: got %b", n, rsp_valid);
         end
         if (n == MC && sbq.size() > 0) held = sbq[0];
         if (n >= MC && n <= MC + 9) begin
            nChecks++;
            if ({rsp_id, rsp_z, rsp_status} !== {held.id, held.z, held.st}) begin
               nFail++;
               $display("[TB] FAIL backpressure_hold n=%0d: got id=%0d z=%h st=%h, required id=%0d z=%h st=%h",
                        n, rsp_id, rsp_z, rsp_status, held.id, held.z, held.st);
            end
         end
         if (n == MC + 9) begin
            rsp_ready = 1'b1;
            if (sbq.size() > 0) void'(sbq.pop_front());
         end
         if (n == 2 * MC + 11 && rsp_valid && sbq.size() > 0) begin
            e = sbq.pop_front();
            nChecks++;
            if ({rsp_id, rsp_z, rsp_status} !== {e.id, e.z, e.st}) begin
               nFail++;
               $display("[TB] FAIL backpressure_rsp2: got id=%0d z=%h st=%h, required id=%0d z=%h st=%h",
                        rsp_id, rsp_z, rsp_status, e.id, e.z, e.st);
            end
         end
      end
   endtask

   task automatic test_reset_mid_busy();
      logic [1:0] win;
      exp_t e;
      $display("[TB] test_reset_mid_busy");
      reqA[0] = 32'hBEEF_0042; reqFunc[0] = 16'h0008; reqRnd[0] = 3'b011;
      rsp_ready = 1'b1;
      req = 4'b0001;
      @(negedge clk);
      expect_grant(win);
      nChecks++;
      if (gnt !== 4'b0001) begin
         nFail++;
         $display("[TB] FAIL midbusy_gnt: got %b, required 0001", gnt);
      end
      req = 4'b0000;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      nChecks++;
      if ({gnt, rsp_valid, rsp_id, rsp_z, rsp_status, fu_a, fu_func, fu_rnd, fu_dg_ctrl} !== '0) begin
         nFail++;
         $display("[TB] FAIL midbusy_async: got valid=%b dg=%b fu_a=%h fu_func=%h, required all 0",
                  rsp_valid, fu_dg_ctrl, fu_a, fu_func);
      end
      if (sbq.size() > 0) void'(sbq.pop_back());
      mPtr = 2'd0;
      req = 4'b0001;
      repeat (2) begin
         @(negedge clk);
         nChecks++;
         if ({gnt, rsp_valid} !== '0) begin
            nFail++;
            $display("[TB] FAIL midbusy_inreset: got gnt=%b valid=%b, required 0", gnt, rsp_valid);
         end
      end
      rst_n = 1'b1;
      for (int n = 0; n < MC + 2; n++) begin
         @(negedge clk);
         if (n == 0) begin
            expect_grant(win);
            req = 4'b0000;
         end
         nChecks++;
         if (gnt !== ((n == 0) ? 4'b0001 : 4'b0000)) begin
            nFail++;
            $display("[TB] FAIL midbusy_regrant n=%0d: got %b", n, gnt);
         end
         nChecks++;
         if (rsp_valid !== (n == MC)) begin
            nFail++;
            $display("[TB] FAIL midbusy_valid n=%0d: got %b", n, rsp_valid);
         end
         if (rsp_valid && sbq.size() > 0) begin
            e = sbq.pop_front();
            nChecks++;
            if ({rsp_id, rsp_z, rsp_status} !== {e.id, e.z, e.st}) begin
               nFail++;
               $display("[TB] FAIL midbusy_rsp: got id=%0d z=%h st=%h, required id=%0d z=%h st=%h",
                        rsp_id, rsp_z, rsp_status, e.id, e.z, e.st);
            end
         end
      end
   endtask

   task automatic test_func_chk();
      logic [1:0] win;
      exp_t e;
      int lat;
      lat = CHK ? 1 : MC;
      $display("[TB] test_func_chk");
      reqA[1] = 32'h7F00_AA55; reqFunc[1] = 16'h0003; reqRnd[1] = 3'b110;
      rsp_ready = 1'b1;
      req = 4'b0010;
      for (int n = 0; n < MC + 3; n++) begin
         @(negedge clk);
         if (n == 0) begin
            expect_grant(win);
            req = 4'b0000;
         end
         nChecks++;
         if (gnt !== ((n == 0) ? 4'b0010 : 4'b0000)) begin
            nFail++;
            $display("[TB] FAIL funcchk_gnt n=%0d: got %b", n, gnt);
         end
         nChecks++;
         if (fu_dg_ctrl !== (!CHK && n < MC)) begin
            nFail++;
            $display("[TB] FAIL funcchk_dg n=%0d: got %b, required %b", n, fu_dg_ctrl, (!CHK && n < MC));
         end
         nChecks++;
         if (rsp_valid !== (n == lat)) begin
            nFail++;
            $display("[TB] FAIL funcchk_valid n=%0d: got %b, required %b", n, rsp_valid, (n == lat));
         end
         if (rsp_valid && sbq.size() > 0) begin
            e = sbq.pop_front();
            nChecks++;
            if ({rsp_id, rsp_z, rsp_status} !== {e.id, e.z, e.st}) begin
               nFail++;
               $display("[TB] FAIL funcchk_rsp: got id=%0d z=%h st=%h, required id=%0d z=%h st=%h",
                        rsp_id, rsp_z, rsp_status, e.id, e.z, e.st);
            end
         end
      end
   endtask

   task automatic test_withdrawn();
      logic [1:0] win;
      exp_t e;
      $display("[TB] test_withdrawn");
      reqA[2] = 32'h0123_4567; reqFunc[2] = 16'h0004; reqRnd[2] = 3'b000;
      reqA[0] = 32'h89AB_CDEF; reqFunc[0] = 16'h0001; reqRnd[0] = 3'b111;
      rsp_ready = 1'b1;
      req = 4'b0100;
      for (int n = 0; n < MC + 7; n++) begin
         @(negedge clk);
         if (n == 0) begin
            expect_grant(win);
            req = 4'b0001;
         end
         if (n == 1) req = 4'b0000;
         nChecks++;
         if (gnt !== ((n == 0) ? 4'b0100 : 4'b0000)) begin
            nFail++;
            $display("[TB] FAIL withdrawn_gnt n=%0d: got %b", n, gnt);
         end
         nChecks++;
         if (rsp_valid !== (n == MC)) begin
            nFail++;
            $display("[TB] FAIL withdrawn_valid n=%0d: got %b, required %b", n, rsp_valid, (n == MC));
         end
         if (rsp_valid && sbq.size() > 0) begin
            e = sbq.pop_front();
            nChecks++;
            if ({rsp_id, rsp_z, rsp_status} !== {e.id, e.z, e.st}) begin
               nFail++;
               $display("[TB] FAIL withdrawn_rsp: got id=%0d z=%h st=%h, required id=%0d z=%h st=%h",
                        rsp_id, rsp_z, rsp_status, e.id, e.z, e.st);
            end
         end
      end
   endtask

   initial begin
      nChecks = 0;
      nFail = 0;
      mPtr = 2'd0;
      rst_n = 1'b0;
      req = '0;
      rsp_ready = 1'b1;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_reset_mid_busy();
      test_func_chk();
      test_withdrawn();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
